exc_commit_ctrl: RTL and testbench



---
 rtl/exc_commit_ctrl_pkg.sv | 31 +++
 rtl/exc_commit_ctrl_if.sv | 41 ++++
 rtl/exc_commit_ctrl_exc_vector.sv | 30 +++
 rtl/exc_commit_ctrl.sv | 85 ++++++++
 tb/tb_exc_commit_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_commit_ctrl_pkg.sv
// rtl/exc_commit_ctrl_pkg.sv - shared codes, CP0 bit positions, vectors and FSM states
package exc_commit_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_CPU  = 5'd11;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int STATUS_BEV = 22;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_BD   = 31;
    localparam int CAUSE_IV   = 23;

    localparam logic [31:0] BEV_BASE    = 32'hBFC0_0200;
    localparam logic [11:0] OFF_REFILL  = 12'h000;
    localparam logic [11:0] OFF_GENERAL = 12'h180;
    localparam logic [11:0] OFF_INT_IV  = 12'h200;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// rtl/exc_commit_ctrl_if.sv - writeback/CP0/fetch bundle around the commit controller
interface exc_commit_ctrl_if;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_bd;
    logic        wb_exc;
    logic [4:0]  wb_exccode;
    logic        wb_refill;
    logic [31:0] wb_badvaddr;
    logic        wb_eret;
    logic        int_sig;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] ebase;
    logic        commit_exc;
    logic        commit_eret;
    logic [4:0]  commit_code;
    logic        commit_bd;
    logic [31:0] commit_epc;
    logic [31:0] commit_bvaddr;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;

    modport master (
        output wb_valid, wb_pc, wb_bd, wb_exc, wb_exccode, wb_refill, wb_badvaddr, wb_eret,
        output int_sig, status, cause, epc, ebase, redirect_ready,
        input  commit_exc, commit_eret, commit_code, commit_bd, commit_epc, commit_bvaddr,
        input  flush, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  wb_valid, wb_pc, wb_bd, wb_exc, wb_exccode, wb_refill, wb_badvaddr, wb_eret,
        input  int_sig, status, cause, epc, ebase, redirect_ready,
        output commit_exc, commit_eret, commit_code, commit_bd, commit_epc, commit_bvaddr,
        output flush, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/exc_commit_ctrl_exc_vector.sv
// rtl/exc_commit_ctrl_exc_vector.sv - redirect target: exception vector or EPC
module exc_vector
    import exc_commit_ctrl_pkg::*;
(
    input  logic         bev,
    input  logic         exl,
    input  logic         iv,
    input  logic         is_int,
    input  logic         refill,
    input  logic [31:12] ebase,
    input  logic [31:0]  epc,
    input  logic         is_eret,
    output logic [31:0]  target
);
    logic [31:0] base;
    logic [11:0] offset;

    always_comb begin
        base   = bev ? BEV_BASE : {ebase, 12'h000};
        // Refill belongs to the instruction's own exception; a winning interrupt masks it.
        if (refill && !exl && !is_int) begin
            offset = OFF_REFILL;
        end else if (is_int && iv) begin
            offset = OFF_INT_IV;
        end else begin
            offset = OFF_GENERAL;
        end
        target = is_eret ? epc : base + {20'h0_0000, offset};
    end
endmodule

// File: rtl/exc_commit_ctrl.sv
// rtl/exc_commit_ctrl.sv - exception/ERET commit and fetch redirect controller
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    exc_commit_ctrl_if.slave   bus
);
    state_t      state;
    logic        exl;
    logic        ev_int;
    logic        ev_exc;
    logic        ev_eret;
    logic        ev_any;
    logic [31:0] exc_epc;
    logic [31:0] target;

    assign exl = bus.status[STATUS_EXL];

    always_comb begin
        ev_int  = (state == ST_IDLE) && bus.wb_valid && bus.int_sig;
        ev_exc  = (state == ST_IDLE) && bus.wb_valid && !bus.int_sig && bus.wb_exc;
        ev_eret = (state == ST_IDLE) && bus.wb_valid && !bus.int_sig && !bus.wb_exc && bus.wb_eret;
        ev_any  = ev_int || ev_exc || ev_eret;
        exc_epc = bus.wb_bd ? bus.wb_pc - 32'd4 : bus.wb_pc;
    end

    exc_vector u_vector (
        .bev     (bus.status[STATUS_BEV]),
        .exl     (exl),
        .iv      (bus.cause[CAUSE_IV]),
        .is_int  (ev_int),
        .refill  (bus.wb_refill),
        .ebase   (bus.ebase[31:12]),
        .epc     (bus.epc),
        .is_eret (ev_eret),
        .target  (target)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state              <= ST_IDLE;
            bus.commit_exc     <= 1'b0;
            bus.commit_eret    <= 1'b0;
            bus.commit_code    <= 5'd0;
            bus.commit_bd      <= 1'b0;
            bus.commit_epc     <= 32'd0;
            bus.commit_bvaddr  <= 32'd0;
            bus.flush          <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= 32'd0;
            bus.busy           <= 1'b0;
        end else begin
            bus.commit_exc  <= 1'b0;
            bus.commit_eret <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ev_any) begin
                        state              <= ST_REDIRECT;
                        bus.commit_exc     <= 1'b1;
                        bus.commit_eret    <= ev_eret;
                        bus.commit_code    <= ev_exc ? bus.wb_exccode : EXC_INT;
                        // With EXL set, CP0 must keep its existing EPC and BD.
                        bus.commit_bd      <= ev_eret ? 1'b0 : (exl ? bus.cause[CAUSE_BD] : bus.wb_bd);
                        bus.commit_epc     <= ev_eret ? 32'd0 : (exl ? bus.epc : exc_epc);
                        bus.commit_bvaddr  <= ev_eret ? 32'd0 : bus.wb_badvaddr;
                        bus.flush          <= 1'b1;
                        bus.redirect_valid <= 1'b1;
                        bus.redirect_pc    <= target;
                        bus.busy           <= 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    if (bus.redirect_ready) begin
                        state              <= ST_IDLE;
                        bus.flush          <= 1'b0;
                        bus.redirect_valid <= 1'b0;
                        bus.busy           <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb/tb_exc_commit_ctrl.sv - scoreboard bench with directed and random stimulus for exc_commit_ctrl
module tb_exc_commit_ctrl;
    import exc_commit_ctrl_pkg::*;

    typedef struct packed {
        logic        eret;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] epc;
        logic [31:0] bva;
        logic [31:0] rpc;
    } exp_t;

    typedef struct packed {
        logic        valid;
        logic        intr;
        logic        exc;
        logic [4:0]  code;
        logic        refill;
        logic        eret;
        logic        bd;
        logic [31:0] pc;
        logic [31:0] bva;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] ebase;
        logic        ready;
        logic        use_exp;
        exp_t        exp;
    } stim_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];
    logic m_busy = 1'b0;
    logic prev_rv = 1'b0;
    logic [31:0] prev_rpc = 32'd0;

    exc_commit_ctrl_if bus();

    exc_commit_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: architectural rules evaluated directly on one writeback sample.
    function automatic exp_t model(input stim_t s);
        exp_t e;
        logic is_int;
        logic is_exc;
        logic exl;
        logic [31:0] base;
        logic [31:0] off;
        e = '0;
        is_int = s.intr;
        is_exc = s.exc && !s.intr;
        exl = s.status[1];
        if (!is_int && !is_exc) begin
            e.eret = 1'b1;
            e.rpc  = s.epc;
            return e;
        end
        e.code = is_int ? 5'd0 : s.code;
        e.bva  = s.bva;
        if (exl) begin
            e.epc = s.epc;
            e.bd  = s.cause[31];
        end else begin
            e.epc = s.bd ? s.pc - 32'd4 : s.pc;
            e.bd  = s.bd;
        end
        base = s.status[22] ? 32'hBFC0_0200 : (s.ebase & 32'hFFFF_F000);
        if (is_exc && s.refill && !exl)  off = 32'h000;
        else if (is_int && s.cause[23])  off = 32'h200;
        else                             off = 32'h180;
        e.rpc = base + off;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        bus.wb_valid       = s.valid;
        bus.int_sig        = s.intr;
        bus.wb_exc         = s.exc;
        bus.wb_exccode     = s.code;
        bus.wb_refill      = s.refill;
        bus.wb_eret        = s.eret;
        bus.wb_bd          = s.bd;
        bus.wb_pc          = s.pc;
        bus.wb_badvaddr    = s.bva;
        bus.status         = s.status;
        bus.cause          = s.cause;
        bus.epc            = s.epc;
        bus.ebase          = s.ebase;
        bus.redirect_ready = s.ready;
    endtask

    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        chk("busy", {31'd0, bus.busy}, {31'd0, m_busy});
        drive(s);
        if (!m_busy && s.valid && (s.intr || s.exc || s.eret)) begin
            q.push_back(s.use_exp ? s.exp : model(s));
            m_busy = 1'b1;
        end else if (m_busy && s.ready) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic idle(input logic ready);
        stim_t s;
        s = '0;
        s.ready = ready;
        step(s);
    endtask

    task automatic reset_and_check();
        stim_t s;
        s = '0;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        drive(s);
        @(posedge clk);
        #1;
        chk("rst_commit_exc", {31'd0, bus.commit_exc}, 32'd0);
        chk("rst_commit_eret", {31'd0, bus.commit_eret}, 32'd0);
        chk("rst_commit_code", {27'd0, bus.commit_code}, 32'd0);
        chk("rst_commit_bd", {31'd0, bus.commit_bd}, 32'd0);
        chk("rst_commit_epc", bus.commit_epc, 32'd0);
        chk("rst_commit_bvaddr", bus.commit_bvaddr, 32'd0);
        chk("rst_flush", {31'd0, bus.flush}, 32'd0);
        chk("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        resetn = 1'b1;
        m_busy = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every commit pulse, watches redirect stability.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.commit_exc) begin
                chk("commit_expected", {31'd0, q.size() != 0}, 32'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("commit_eret", {31'd0, bus.commit_eret}, {31'd0, e.eret});
                    chk("commit_code", {27'd0, bus.commit_code}, {27'd0, e.code});
                    chk("commit_bd", {31'd0, bus.commit_bd}, {31'd0, e.bd});
                    chk("commit_epc", bus.commit_epc, e.epc);
                    chk("commit_bvaddr", bus.commit_bvaddr, e.bva);
                    chk("redirect_pc", bus.redirect_pc, e.rpc);
                    chk("commit_flush", {31'd0, bus.flush}, 32'd1);
                    chk("commit_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
                end
            end
            if (prev_rv && bus.redirect_valid && !bus.commit_exc)
                chk("redirect_pc_stable", bus.redirect_pc, prev_rpc);
            chk("flush_eq_redirect_valid", {31'd0, bus.flush}, {31'd0, bus.redirect_valid});
        end
        prev_rv  = resetn && bus.redirect_valid;
        prev_rpc = bus.redirect_pc;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        logic [4:0] codes [0:7];
        codes = '{EXC_MOD, EXC_TLBL, EXC_TLBS, EXC_ADEL, EXC_SYS, EXC_RI, EXC_CPU, EXC_OV};
        s = '0;
        drive(s);
        reset_and_check();

        // BEV vector, RI, ready only on the third REDIRECT cycle.
        s = '0; s.valid = 1; s.exc = 1; s.code = EXC_RI; s.pc = 32'hBFC0_0100;
        s.status = 32'h0040_0000; s.bva = 32'h1234_5678; s.use_exp = 1;
        s.exp = '{1'b0, EXC_RI, 1'b0, 32'hBFC0_0100, 32'h1234_5678, 32'hBFC0_0380};
        step(s); idle(0); idle(0); idle(1); idle(0);

        // Interrupt in a delay slot, IV=0 then IV=1.
        s = '0; s.valid = 1; s.intr = 1; s.pc = 32'h8000_2008; s.bd = 1;
        s.ebase = 32'h8000_1000; s.bva = 32'h0000_0abc; s.use_exp = 1;
        s.exp = '{1'b0, EXC_INT, 1'b1, 32'h8000_2004, 32'h0000_0abc, 32'h8000_1180};
        step(s); idle(1); idle(0);
        s.cause = 32'h0080_0000; s.exp.rpc = 32'h8000_1200;
        step(s); idle(1); idle(0);

        // TLB refill with EXL=0, then EXL=1 preserving EPC/BD.
        s = '0; s.valid = 1; s.exc = 1; s.code = EXC_TLBL; s.refill = 1; s.pc = 32'h8000_3000;
        s.ebase = 32'h8000_1000; s.bva = 32'h0040_0000; s.use_exp = 1;
        s.exp = '{1'b0, EXC_TLBL, 1'b0, 32'h8000_3000, 32'h0040_0000, 32'h8000_1000};
        step(s); idle(1); idle(0);
        s.status = 32'h0000_0002; s.epc = 32'h8000_0040; s.bd = 1; s.pc = 32'h8000_3004;
        s.exp = '{1'b0, EXC_TLBL, 1'b0, 32'h8000_0040, 32'h0040_0000, 32'h8000_1180};
        step(s); idle(1); idle(0);

        // ERET alone, then ERET masked by a CpU exception.
        s = '0; s.valid = 1; s.eret = 1; s.epc = 32'h8000_0400; s.status = 32'h0000_0002;
        s.pc = 32'h8000_5000; s.bva = 32'hdead_beef; s.use_exp = 1;
        s.exp = '{1'b1, 5'd0, 1'b0, 32'd0, 32'd0, 32'h8000_0400};
        step(s); idle(1); idle(0);
        s = '0; s.valid = 1; s.eret = 1; s.exc = 1; s.code = EXC_CPU; s.pc = 32'h8000_4000;
        s.ebase = 32'h8000_1000; s.epc = 32'h8000_0400; s.use_exp = 1;
        s.exp = '{1'b0, EXC_CPU, 1'b0, 32'h8000_4000, 32'd0, 32'h8000_1180};
        step(s); idle(1); idle(0);

        // int_sig without wb_valid, event during REDIRECT, reset mid-REDIRECT.
        s = '0; s.intr = 1; s.exc = 1; s.ebase = 32'h8000_1000;
        step(s); idle(0);
        s = '0; s.valid = 1; s.exc = 1; s.code = EXC_OV; s.pc = 32'h8000_6000; s.ebase = 32'h8000_1000;
        step(s);
        s.pc = 32'h8000_7000; s.code = EXC_SYS;
        step(s); step(s);
        reset_and_check();
        idle(0);

        // redirect_ready tied high with events every cycle: commits at t+1 and t+3.
        for (int i = 0; i < 4; i++) begin
            s = '0; s.valid = 1; s.exc = 1; s.code = codes[i]; s.pc = 32'h8000_8000 + 32'(i * 16);
            s.ebase = 32'h9000_0000; s.bva = 32'(i); s.ready = 1;
            step(s);
        end
        idle(1); idle(0);

        for (int i = 0; i < 600; i++) begin
            s = '0;
            s.valid  = $urandom_range(0, 9) < 7;
            s.intr   = $urandom_range(0, 9) < 2;
            s.exc    = $urandom_range(0, 9) < 3;
            s.code   = codes[$urandom_range(0, 7)];
            s.refill = s.exc && !s.intr && ($urandom_range(0, 1) == 1);
            s.eret   = $urandom_range(0, 9) < 2;
            s.bd     = $urandom_range(0, 1) == 1;
            s.pc     = $urandom & 32'hFFFF_FFFC;
            s.bva    = $urandom;
            s.status = $urandom;
            s.cause  = $urandom;
            s.epc    = $urandom;
            s.ebase  = $urandom;
            s.ready  = $urandom_range(0, 2) != 0;
            step(s);
        end
        idle(1); idle(1); idle(0); idle(0);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
